// File: rtl/unpack_fifo.sv
// -----------------------------------------------------------------------------
// unpack_fifo
//
// Width-converting FIFO. Each accepted write stores PAR_WRITE words; each
// served read returns PAR_READ words. Words leave in the same order they
// arrived, word 0 of a write first.
//
// Parameters
//   NUM_BIT   bits per word
//   NUM_REG   storage depth in words (must equal 2**ADDR_REG)
//   ADDR_REG  pointer width in bits
//   PAR_WRITE words accepted per write
//   PAR_READ  words delivered per read (PAR_READ < PAR_WRITE <= NUM_REG)
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous, active-low reset
//   write_en  write request
//   read_en   read request
//   din       packed write data, word i = din[i*NUM_BIT +: NUM_BIT]
//   dout      registered read data, word j = dout[j*NUM_BIT +: NUM_BIT]
//   full      high when a write cannot be accepted
//   empty     high when a read cannot be served
//   ready     ~full
//   valid     dout carries the data of the read served on the last edge
//
// Handshake: a write is accepted on a rising edge iff write_en && ready
// (ready == ~full); a read is served on a rising edge iff read_en && !empty,
// and that same edge loads dout and raises valid for exactly one cycle.
// Requests made while the matching flag blocks them are dropped silently;
// the requester must hold the request until the flag allows it.
// -----------------------------------------------------------------------------
module unpack_fifo #(
    parameter int NUM_BIT   = 4,
    parameter int NUM_REG   = 8,
    parameter int ADDR_REG  = 3,
    parameter int PAR_WRITE = 2,
    parameter int PAR_READ  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [PAR_WRITE*NUM_BIT-1:0]  din,
    output logic [PAR_READ*NUM_BIT-1:0]   dout,
    output logic                          full,
    output logic                          empty,
    output logic                          ready,
    output logic                          valid
);

    // Pointer steps wrap naturally because NUM_REG == 2**ADDR_REG.
    localparam logic [ADDR_REG-1:0] PW_PTR     = ADDR_REG'(PAR_WRITE);
    localparam logic [ADDR_REG-1:0] PR_PTR     = ADDR_REG'(PAR_READ);
    localparam logic [ADDR_REG:0]   PW_CNT     = (ADDR_REG+1)'(PAR_WRITE);
    localparam logic [ADDR_REG:0]   PR_CNT     = (ADDR_REG+1)'(PAR_READ);
    localparam logic [ADDR_REG:0]   FULL_LIMIT = (ADDR_REG+1)'(NUM_REG - PAR_WRITE);

    logic [NUM_BIT-1:0]  mem [NUM_REG];
    logic [ADDR_REG-1:0] wptr;
    logic [ADDR_REG-1:0] rptr;
    logic [ADDR_REG:0]   count;
    logic                wr_fire;
    logic                rd_fire;

    // Flags come straight from the occupancy count. "full" means there is
    // no room for a whole write, "empty" means fewer than a whole read.
    assign full  = (count > FULL_LIMIT);
    assign empty = (count < PR_CNT);
    assign ready = ~full;

    // Both decisions use the pre-edge flags, so a simultaneous read and
    // write are judged independently of each other.
    assign wr_fire = write_en & ~full;
    assign rd_fire = read_en & ~empty;

    // Storage is deliberately not reset: after reset count is 0, so no
    // stale word can be reached before it is overwritten.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                mem[wptr + ADDR_REG'(i)] <= din[i*NUM_BIT +: NUM_BIT];
            end
        end
    end

    // Control state and registered read port. A read on the same edge as a
    // write sees the pre-edge memory (non-blocking update), and since reads
    // only touch occupied slots while writes only touch free ones, the two
    // never address the same word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + PW_PTR;
            end
            if (rd_fire) begin
                for (int j = 0; j < PAR_READ; j++) begin
                    dout[j*NUM_BIT +: NUM_BIT] <= mem[rptr + ADDR_REG'(j)];
                end
                rptr  <= rptr + PR_PTR;
                valid <= 1'b1;
            end else begin
                // dout keeps its last value; only valid drops.
                valid <= 1'b0;
            end
            count <= count + (wr_fire ? PW_CNT : '0) - (rd_fire ? PR_CNT : '0);
        end
    end

endmodule

// File: tb/tb_unpack_fifo.sv
// -----------------------------------------------------------------------------
// tb_unpack_fifo
//
// Self-checking bench for unpack_fifo. The reference model is a plain word
// queue: writes push PAR_WRITE words, reads pop PAR_READ words, and the flags
// follow from the queue size.
// -----------------------------------------------------------------------------
module tb_unpack_fifo;

    localparam int NB = 4;
    localparam int NR = 8;
    localparam int AR = 3;
    localparam int PW = 2;
    localparam int PR = 1;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               write_en = 1'b0;
    logic               read_en = 1'b0;
    logic [PW*NB-1:0]   din = '0;
    logic [PR*NB-1:0]   dout;
    logic               full;
    logic               empty;
    logic               ready;
    logic               valid;

    always #5 clk = ~clk;

    unpack_fifo #(
        .NUM_BIT(NB), .NUM_REG(NR), .ADDR_REG(AR), .PAR_WRITE(PW), .PAR_READ(PR)
    ) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .din(din), .dout(dout), .full(full), .empty(empty),
        .ready(ready), .valid(valid)
    );

    // ---------------- model / scoreboard ----------------
    logic [NB-1:0]    exp_q[$];
    logic [PR*NB-1:0] exp_dout  = '0;
    logic             exp_valid = 1'b0;
    int               checks = 0;
    int               passed = 0;

    function automatic logic exp_full();
        return exp_q.size() > NR - PW;
    endfunction

    function automatic logic exp_empty();
        return exp_q.size() < PR;
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of requests and advances the model by one edge.
    // Returns 1 in wr_ok when the model says the write was accepted.
    task automatic step(input logic w, input logic r, input logic [PW*NB-1:0] d,
                        output logic wr_ok);
        logic m_full;
        logic m_empty;
        @(negedge clk);
        write_en = w;
        read_en  = r;
        din      = d;
        m_full   = exp_full();
        m_empty  = exp_empty();
        @(posedge clk);
        #1;
        if (r && !m_empty) begin
            for (int j = 0; j < PR; j++) exp_dout[j*NB +: NB] = exp_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        wr_ok = w && !m_full;
        if (wr_ok) begin
            for (int i = 0; i < PW; i++) exp_q.push_back(d[i*NB +: NB]);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic ok;
        // Power-on reset.
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dout, valid, full, empty, ready} !== {{(PR*NB){1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1})
            $display("FAIL reset_por dout=%h v=%b f=%b e=%b r=%b, want 0 0 0 1 1",
                     dout, valid, full, empty, ready);
        else passed++;
        @(negedge clk) rst = 1'b1;

        // Build count=5 with a nonzero dout, then reset mid-cycle.
        step(1, 0, 8'h21, ok);
        step(1, 0, 8'h43, ok);
        step(1, 0, 8'h65, ok);
        step(0, 1, 8'h00, ok);
        checks++;
        if (exp_q.size() != 5 || dout !== 4'h1 || valid !== 1'b1)
            $display("FAIL reset_pre count=%0d dout=%h v=%b, want 5 1 1", exp_q.size(), dout, valid);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if ({dout, valid, full, empty, ready} !== {{(PR*NB){1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1})
            $display("FAIL reset_async dout=%h v=%b f=%b e=%b r=%b, want 0 0 0 1 1",
                     dout, valid, full, empty, ready);
        else passed++;
        exp_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        @(negedge clk) rst = 1'b1;

        // A read right after release must not expose stale words.
        step(0, 1, 8'h00, ok);
        checks++;
        if (valid !== 1'b0 || dout !== 4'h0 || empty !== 1'b1)
            $display("FAIL reset_stale v=%b dout=%h e=%b, want 0 0 1", valid, dout, empty);
        else passed++;
        step(1, 0, 8'h9E, ok);
        step(0, 1, 8'h00, ok);
        checks++;
        if (dout !== 4'hE || valid !== 1'b1)
            $display("FAIL reset_first dout=%h v=%b, want e 1", dout, valid);
        else passed++;
        step(0, 1, 8'h00, ok);
        idle_inputs();
    endtask

    task automatic test_basic_unpack();
        logic ok;
        step(1, 0, 8'hB2, ok);
        step(0, 1, 8'h00, ok);
        checks++;
        if (dout !== 4'h2 || valid !== 1'b1)
            $display("FAIL unpack_w0 dout=%h v=%b, want 2 1", dout, valid);
        else passed++;
        step(0, 1, 8'h00, ok);
        checks++;
        if (dout !== 4'hB || valid !== 1'b1 || empty !== 1'b1)
            $display("FAIL unpack_w1 dout=%h v=%b e=%b, want b 1 1", dout, valid, empty);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_full();
        logic ok;
        logic [7:0] pat [4];
        pat[0] = 8'h10; pat[1] = 8'h32; pat[2] = 8'h54; pat[3] = 8'h76;
        for (int k = 0; k < 4; k++) step(1, 0, pat[k], ok);
        checks++;
        if (full !== 1'b1 || ready !== 1'b0)
            $display("FAIL full_flag f=%b r=%b, want 1 0", full, ready);
        else passed++;
        step(1, 0, 8'hFF, ok);
        checks++;
        if (ok !== 1'b0 || full !== 1'b1 || exp_q.size() != 8)
            $display("FAIL full_ignore ok=%b f=%b size=%0d, want 0 1 8", ok, full, exp_q.size());
        else passed++;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 8'h00, ok);
            checks++;
            if (dout !== 4'(k) || valid !== 1'b1 || dout !== exp_dout)
                $display("FAIL full_read%0d dout=%h v=%b, want %h 1", k, dout, valid, 4'(k));
            else passed++;
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0)
            $display("FAIL full_drain e=%b f=%b, want 1 0", empty, full);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_odd_boundary();
        logic ok;
        for (int k = 0; k < 4; k++) step(1, 0, 8'($urandom_range(0, 255)), ok);
        step(0, 1, 8'h00, ok);
        checks++;
        if (full !== 1'b1 || exp_q.size() != 7)
            $display("FAIL odd_full7 f=%b size=%0d, want 1 7", full, exp_q.size());
        else passed++;
        step(1, 0, 8'hAA, ok);
        checks++;
        if (ok !== 1'b0 || full !== 1'b1)
            $display("FAIL odd_ignore ok=%b f=%b, want 0 1", ok, full);
        else passed++;
        step(0, 1, 8'h00, ok);
        checks++;
        if (full !== 1'b0 || ready !== 1'b1 || dout !== exp_dout)
            $display("FAIL odd_six f=%b r=%b dout=%h, want 0 1 %h", full, ready, dout, exp_dout);
        else passed++;
        step(1, 0, 8'hC5, ok);
        checks++;
        if (ok !== 1'b1 || full !== 1'b1 || exp_q.size() != 8)
            $display("FAIL odd_accept ok=%b f=%b size=%0d, want 1 1 8", ok, full, exp_q.size());
        else passed++;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 8'h00, ok);
            checks++;
            if (dout !== exp_dout || valid !== 1'b1)
                $display("FAIL odd_read%0d dout=%h v=%b, want %h 1", k, dout, valid, exp_dout);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic ok;
        step(1, 0, 8'hA7, ok);
        step(0, 1, 8'h00, ok);
        step(1, 1, 8'h3C, ok);
        checks++;
        if (dout !== 4'hA || valid !== 1'b1 || exp_q.size() != 2 || empty !== 1'b0)
            $display("FAIL simul dout=%h v=%b size=%0d e=%b, want a 1 2 0",
                     dout, valid, exp_q.size(), empty);
        else passed++;
        step(0, 1, 8'h00, ok);
        step(0, 1, 8'h00, ok);
        checks++;
        if (dout !== 4'h3 || empty !== 1'b1)
            $display("FAIL simul_drain dout=%h e=%b, want 3 1", dout, empty);
        else passed++;
        step(0, 1, 8'h00, ok);
        checks++;
        if (valid !== 1'b0 || dout !== 4'h3)
            $display("FAIL empty_read v=%b dout=%h, want 0 3", valid, dout);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic ok;
        int   written = 0;
        int   reads   = 0;
        int   cyc     = 0;
        while ((written < 24 || exp_q.size() > 0) && cyc < 200) begin
            step(written < 24, 1'b1, {4'(written + 1), 4'(written)}, ok);
            if (ok) written += PW;
            if (exp_valid) begin
                checks++;
                if (dout !== 4'(reads) || valid !== 1'b1)
                    $display("FAIL wrap_order n=%0d dout=%h v=%b, want %h 1", reads, dout, valid, 4'(reads));
                else passed++;
                reads++;
            end
            checks++;
            if ({full, empty, ready, valid} !== {exp_full(), exp_empty(), ~exp_full(), exp_valid})
                $display("FAIL wrap_flags cyc=%0d fevr=%b%b%b%b want %b%b%b%b", cyc,
                         full, empty, ready, valid, exp_full(), exp_empty(), ~exp_full(), exp_valid);
            else passed++;
            cyc++;
        end
        checks++;
        if (reads != 24)
            $display("FAIL wrap_count reads=%0d, want 24", reads);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic ok;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), ok);
            checks++;
            if ({dout, valid, full, empty, ready} !==
                {exp_dout, exp_valid, exp_full(), exp_empty(), ~exp_full()})
                $display("FAIL rand cyc=%0d dout=%h v=%b f=%b e=%b r=%b want %h %b %b %b %b",
                         cyc, dout, valid, full, empty, ready,
                         exp_dout, exp_valid, exp_full(), exp_empty(), ~exp_full());
            else passed++;
        end
        idle_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_unpack();
        test_full();
        test_odd_boundary();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/unpack_fifo.md
UNPACK_FIFO -- requirements
Module: unpack_fifo

Interface
REQ-001 The block SHALL have parameter NUM_BIT, default 4: bits per word.
REQ-002 The block SHALL have parameter NUM_REG, default 8: storage depth in words; equals 2**ADDR_REG.
REQ-003 The block SHALL have parameter ADDR_REG, default 3: pointer width in bits.
REQ-004 The block SHALL have parameter PAR_WRITE, default 2: words accepted per write.
REQ-005 The block SHALL have parameter PAR_READ, default 1: words delivered per read; PAR_READ < PAR_WRITE <= NUM_REG.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port write_en, input, 1 bit: write request.
REQ-009 The block SHALL have port read_en, input, 1 bit: read request.
REQ-010 The block SHALL have port din, input, PAR_WRITE*NUM_BIT bits: packed write data; word i is din[i*NUM_BIT +: NUM_BIT].
REQ-011 The block SHALL have port dout, output, PAR_READ*NUM_BIT bits: registered read data; word j is dout[j*NUM_BIT +: NUM_BIT].
REQ-012 The block SHALL have port full, output, 1 bit: high when a write cannot be accepted.
REQ-013 The block SHALL have port empty, output, 1 bit: high when a read cannot be served.
REQ-014 The block SHALL have port ready, output, 1 bit: equal to ~full.
REQ-015 The block SHALL have port valid, output, 1 bit: dout carries the data of a served read.

Function
REQ-016 The block SHALL hold NUM_REG words, a write pointer wptr, a read pointer rptr (ADDR_REG bits each, wrapping modulo NUM_REG) and an occupancy count (0..NUM_REG, ADDR_REG+1 bits).
REQ-017 The block SHALL drive full = (count > NUM_REG - PAR_WRITE) and empty = (count < PAR_READ), combinationally from count.
REQ-018 The block SHALL accept a write on a rising edge when write_en=1 and full=0: word i of din goes to mem[wptr+i], in order i=0 first, and wptr advances by PAR_WRITE.
REQ-019 The block SHALL serve a read on a rising edge when read_en=1 and empty=0: dout word j takes mem[rptr+j], rptr advances by PAR_READ, and valid is set to 1.
REQ-020 The block SHALL clear valid to 0 on every edge that serves no read, and dout SHALL hold its last value on that edge.
REQ-021 The block SHALL ignore write_en while full=1 and read_en while empty=1, with no change to pointers, count or memory.
REQ-022 The block SHALL evaluate a simultaneous read and write against the pre-edge flags and update count as count + PAR_WRITE*w - PAR_READ*r in the same edge.
REQ-023 A read that is simultaneous with a write SHALL return only data stored before that edge.
REQ-024 Read data latency SHALL be one cycle: dout and valid update on the same edge that accepts read_en.

Reset
REQ-025 When rst=0 the block SHALL immediately and asynchronously set wptr=0, rptr=0, count=0, dout=0 and valid=0, giving empty=1, full=0 and ready=1.
REQ-026 Memory contents SHALL NOT be reset, and no stale word SHALL become readable after reset.
REQ-027 A reset asserted mid-operation SHALL abandon all stored words; the first read after release SHALL return the first word written after release.

Verification
REQ-028 Reset check: drive rst=0 with count=5 -> empty=1, full=0, ready=1, valid=0 and dout=0 immediately, before the next edge.
REQ-029 Basic unpack check: write din=8'hB2, then read on two edges -> dout=4'h2 with valid=1, then dout=4'hB with valid=1, then empty=1.
REQ-030 Full check: write 8'h10, 8'h32, 8'h54, 8'h76 -> full=1 and ready=0 after the 4th write; a 5th write of 8'hFF is ignored; eight reads return 0,1,2,3,4,5,6,7, then empty=1.
REQ-031 Odd-count boundary: with count=7, a write is ignored because full=1; after one read (count=6) full=0 and a write is accepted, giving count=8.
REQ-032 Simultaneous and empty access: at count=1 (word 4'hA), read+write of 8'h3C -> dout=4'hA and count=2; then read_en held with empty=1 -> valid=0 and dout unchanged.
REQ-033 Wrap-around: a continuous write/read stream of 24 words crossing the pointer wrap three times -> output order identical to input order, with no flag glitches.
